// File: rtl/vdp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vdp_pkg
//  Description : Shared widths, default FIFO depth, grant source encoding and
//                a constant-foldable ceil(log2) helper for the VDP register
//                write path.
//  Revision    : 1.0  initial release
// ============================================================================
package vdp_pkg;

   localparam int VDP_REG_ADDR_WIDTH = 5;
   localparam int VDP_DATA_WIDTH     = 16;
   localparam int VDP_FIFO_DEPTH     = 4;

   // Which requester owns the register write slot in a given cycle
   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_AUX  = 2'd1,
      GRANT_HOST = 2'd2
   } grant_src_e;

   // ceil(log2(value)); returns 0 for value <= 1
   function automatic int vdp_clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vdp_reg_write_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vdp_reg_write_fifo
//  Description : Synchronous FIFO with show-ahead head output. Pointers carry
//                an extra wrap bit so full and empty are distinguished without
//                a separate counter. A push is accepted while full when a pop
//                happens in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module vdp_reg_write_fifo
   import vdp_pkg::*;
#(
   parameter int WIDTH = VDP_REG_ADDR_WIDTH + VDP_DATA_WIDTH,
   parameter int DEPTH = VDP_FIFO_DEPTH
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   output logic                       full,
   output logic                       empty,
   output logic [vdp_clog2(DEPTH):0]  level
);

   localparam int PTR_WIDTH = vdp_clog2(DEPTH);

   logic [PTR_WIDTH:0]  wr_ptr;
   logic [PTR_WIDTH:0]  rd_ptr;
   logic [WIDTH-1:0]    mem [DEPTH];
   logic                do_push;
   logic                do_pop;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                      (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
   assign level     = wr_ptr - rd_ptr;
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem[rd_ptr[PTR_WIDTH-1:0]];

   // Advance read/write pointers on accepted pop/push
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + (PTR_WIDTH+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (PTR_WIDTH+1)'(1);
         end
      end
   end

   // Entry storage, written at the current write pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_push) begin
         mem[wr_ptr[PTR_WIDTH-1:0]] <= push_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vdp_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vdp_reg_write_arbiter
//  Description : Merges CPU register writes (buffered in a small FIFO) and
//                NUM_AUX non-stallable aux write sources onto the single VDP
//                register write port. Aux sources win over the CPU FIFO and
//                lower aux index wins among aux; losing aux writes are dropped
//                and counted. CPU reads are held off until the FIFO is empty.
//  Revision    : 1.0  initial release
// ============================================================================
module vdp_reg_write_arbiter
   import vdp_pkg::*;
#(
   parameter int HOST_ADDR_WIDTH = 6,
   parameter int REG_ADDR_WIDTH  = VDP_REG_ADDR_WIDTH,
   parameter int DATA_WIDTH      = VDP_DATA_WIDTH,
   parameter int FIFO_DEPTH      = VDP_FIFO_DEPTH,
   parameter int NUM_AUX         = 2,
   parameter int CONFLICT_WIDTH  = 8
)(
   input  logic                               clk,
   input  logic                               reset,
   input  logic [HOST_ADDR_WIDTH-1:0]         host_address,
   input  logic                               host_write_en,
   input  logic [DATA_WIDTH-1:0]              host_write_data,
   input  logic                               host_read_en,
   output logic                               ready,
   output logic [REG_ADDR_WIDTH-1:0]          read_address,
   input  logic                               vram_write_pending,
   input  logic [NUM_AUX-1:0]                 aux_write_en,
   input  logic [NUM_AUX*REG_ADDR_WIDTH-1:0]  aux_write_address,
   input  logic [NUM_AUX*DATA_WIDTH-1:0]      aux_write_data,
   output logic                               register_write_en,
   output logic [REG_ADDR_WIDTH-1:0]          register_write_address,
   output logic [DATA_WIDTH-1:0]              register_write_data,
   output logic [vdp_clog2(FIFO_DEPTH):0]     fifo_level,
   output logic [CONFLICT_WIDTH-1:0]          conflict_count
);

   localparam int ENTRY_WIDTH = REG_ADDR_WIDTH + DATA_WIDTH;

   // FIFO interface
   logic [ENTRY_WIDTH-1:0]     fifo_head;
   logic [ENTRY_WIDTH-1:0]     fifo_push_data;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       fifo_pop;

   // Aux sources unpacked per index
   logic [REG_ADDR_WIDTH-1:0]  aux_addr [NUM_AUX];
   logic [DATA_WIDTH-1:0]      aux_data [NUM_AUX];

   // Arbitration results
   grant_src_e                 grant_src;
   logic [REG_ADDR_WIDTH-1:0]  grant_addr;
   logic [DATA_WIDTH-1:0]      grant_data;
   logic                       aux_found;
   logic [CONFLICT_WIDTH-1:0]  conflict_next;

   // Host handshake
   logic                       write_accept;
   logic                       read_accept;
   logic                       write_accepted;
   logic                       read_accepted;
   logic                       read_stage;

   generate
      for (genvar i = 0; i < NUM_AUX; i++) begin : g_aux_unpack
         assign aux_addr[i] = aux_write_address[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
         assign aux_data[i] = aux_write_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // Host address bits above the register file range are ignored by design
   generate
      if (HOST_ADDR_WIDTH > REG_ADDR_WIDTH) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^host_address[HOST_ADDR_WIDTH-1:REG_ADDR_WIDTH];
      end
   endgenerate

   assign fifo_push_data = {host_address[REG_ADDR_WIDTH-1:0], host_write_data};

   vdp_reg_write_fifo #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (write_accept),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // Pick the write slot owner: lowest aux index first, then the FIFO head
   // when VRAM is idle; every extra aux requester is a dropped write
   always_comb begin
      grant_src     = GRANT_NONE;
      grant_addr    = '0;
      grant_data    = '0;
      aux_found     = 1'b0;
      conflict_next = conflict_count;
      for (int i = 0; i < NUM_AUX; i++) begin
         if (aux_write_en[i]) begin
            if (!aux_found) begin
               aux_found  = 1'b1;
               grant_addr = aux_addr[i];
               grant_data = aux_data[i];
            end else if (conflict_next != '1) begin
               conflict_next = conflict_next + CONFLICT_WIDTH'(1);
            end
         end
      end
      if (aux_found) begin
         grant_src = GRANT_AUX;
      end else if (!fifo_empty && !vram_write_pending) begin
         grant_src  = GRANT_HOST;
         grant_addr = fifo_head[ENTRY_WIDTH-1 -: REG_ADDR_WIDTH];
         grant_data = fifo_head[DATA_WIDTH-1:0];
      end
   end

   assign fifo_pop = (grant_src == GRANT_HOST);

   // A full FIFO still takes the write in a cycle where the head pops; a
   // read only goes ahead once every buffered write has drained
   assign write_accept = host_write_en && !write_accepted && (!fifo_full || fifo_pop);
   assign read_accept  = host_read_en && !read_accepted && fifo_empty && !write_accept;

   // Register the granted write onto the register file port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         register_write_en      <= 1'b0;
         register_write_address <= '0;
         register_write_data    <= '0;
      end else begin
         register_write_en <= (grant_src != GRANT_NONE);
         if (grant_src != GRANT_NONE) begin
            register_write_address <= grant_addr;
            register_write_data    <= grant_data;
         end
      end
   end

   // Saturating count of dropped aux writes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         conflict_count <= '0;
      end else begin
         conflict_count <= conflict_next;
      end
   end

   // Accepted flags stop a held request from being taken twice
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_accepted <= 1'b0;
         read_accepted  <= 1'b0;
      end else begin
         if (!host_write_en) begin
            write_accepted <= 1'b0;
         end else if (write_accept) begin
            write_accepted <= 1'b1;
         end
         if (!host_read_en) begin
            read_accepted <= 1'b0;
         end else if (read_accept) begin
            read_accepted <= 1'b1;
         end
      end
   end

   // Completion pulse: one cycle after a write accept, two after a read
   // accept so the register file has a cycle to return data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         read_stage   <= 1'b0;
         ready        <= 1'b0;
         read_address <= '0;
      end else begin
         read_stage <= read_accept;
         ready      <= write_accept || read_stage;
         if (read_accept) begin
            read_address <= host_address[REG_ADDR_WIDTH-1:0];
         end
      end
   end

endmodule
`default_nettype wire
